// File: rtl/ascii2nt_pkg.sv
// Shared types for the ASCII-to-nucleotide stream: 3-bit nt codes, complement, sequence FSM states.
// Optional invalid-byte flagging is enabled by defining ASCII2NT_BAD_EN.
package ascii2nt_pkg;

    typedef logic [2:0] nt_t;

    localparam nt_t NT_N = 3'd0;
    localparam nt_t NT_A = 3'd1;
    localparam nt_t NT_C = 3'd2;
    localparam nt_t NT_G = 3'd3;
    localparam nt_t NT_T = 3'd4;

    typedef enum logic {
        SEQ_START = 1'b0,
        SEQ_BODY  = 1'b1
    } seq_state_t;

    function automatic nt_t nt_comp(input nt_t c);
        nt_t r;
        case (c)
            NT_A:    r = NT_T;
            NT_C:    r = NT_G;
            NT_G:    r = NT_C;
            NT_T:    r = NT_A;
            default: r = NT_N;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ascii2nt_stream_lane_decode.sv
// One-lane ASCII byte to nt code decoder; bad-byte flag exists only with ASCII2NT_BAD_EN.
// Purely combinational, no latency, no flow control.
module nt_lane_decode
    import ascii2nt_pkg::*;
(
    input  logic [7:0] i_byte,
    output nt_t        o_nt
`ifdef ASCII2NT_BAD_EN
    ,
    output logic       o_bad
`endif
);

    always_comb begin
        case (i_byte)
            "A", "a": o_nt = NT_A;
            "C", "c": o_nt = NT_C;
            "G", "g": o_nt = NT_G;
            "T", "t": o_nt = NT_T;
            default:  o_nt = NT_N;
        endcase
    end

`ifdef ASCII2NT_BAD_EN
    always_comb begin
        case (i_byte)
            "A", "a", "C", "c", "G", "g", "T", "t", "N", "n": o_bad = 1'b0;
            default:                                          o_bad = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/ascii2nt_stream.sv
// Multi-lane ASCII to nt converter with per-beat reverse-complement and per-sequence len/N counters (ASCII2NT_BAD_EN adds out_bad).
// Latency: 1 cycle from acceptance to out_valid with an empty buffer; 1 beat/cycle sustained.
// Backpressure: 2-entry output buffer; registered in_ready drops when both entries are occupied.
module ascii2nt_stream
    import ascii2nt_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_ascii,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    input  logic                 rc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*LANES-1:0]   out_nt,
    output logic [LANES-1:0]     out_keep,
    output logic                 out_last,
    output logic [LEN_W-1:0]     out_len,
    output logic [LEN_W-1:0]     out_ncount,
    output logic [LANES-1:0]     out_bad
);

    localparam int KW = $clog2(LANES + 1);

    typedef struct packed {
        logic [3*LANES-1:0] nt;
        logic [LANES-1:0]   keep;
        logic               last;
        logic [LEN_W-1:0]   len;
        logic [LEN_W-1:0]   ncount;
        logic [LANES-1:0]   bad;
    } entry_t;

    seq_state_t       r_state, w_state_nxt;
    logic             r_rc_q, w_seq_start, w_rc_eff;
    logic             r_in_ready, w_push, w_pop;
    logic [1:0]       r_cnt, w_cnt_nxt;
    logic             r_wr, r_rd;
    entry_t           r_buf [2];
    entry_t           w_entry;
    logic [LEN_W-1:0] r_len, r_nc, w_len_base, w_nc_base;
    logic [LEN_W:0]   w_len_sum, w_nc_sum;
    logic [KW-1:0]    w_k, w_nn;
    logic [3*LANES-1:0] w_nt;
    logic [LANES-1:0] w_keep, w_lane_bad;
    nt_t              w_code [LANES];
`ifdef ASCII2NT_BAD_EN
    logic [LANES-1:0] w_bad;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nt_lane_decode u_dec (
            .i_byte (in_ascii[8*g +: 8]),
            .o_nt   (w_code[g])
`ifdef ASCII2NT_BAD_EN
            ,
            .o_bad  (w_bad[g])
`endif
        );
    end

    assign w_push   = in_valid && r_in_ready;
    assign w_pop    = (r_cnt != 2'd0) && out_ready;
    assign in_ready = r_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= SEQ_START;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_push) begin
            case (r_state)
                SEQ_START: if (!in_last) w_state_nxt = SEQ_BODY;
                SEQ_BODY:  if (in_last)  w_state_nxt = SEQ_START;
                default:   w_state_nxt = SEQ_START;
            endcase
        end
    end

    // A first beat uses the live rc; later beats reuse the value latched on the first.
    always_comb begin
        w_seq_start = (r_state == SEQ_START);
        w_rc_eff    = w_seq_start ? rc : r_rc_q;
    end

    always_comb begin
        w_k = '0;
        for (int i = 0; i < LANES; i++) w_k = w_k + KW'(in_keep[i]);
    end

    always_comb begin
        w_nt       = '0;
        w_keep     = '0;
        w_nn       = '0;
        w_lane_bad = '0;
        for (int i = 0; i < LANES; i++) begin
            if (KW'(i) < w_k) begin
                w_keep[i] = 1'b1;
                if (w_code[i] == NT_N) w_nn = w_nn + KW'(1);
                for (int j = 0; j < LANES; j++) begin
                    if (w_rc_eff ? (KW'(j) == w_k - KW'(i + 1)) : (j == i)) begin
                        w_nt[3*i +: 3] = w_rc_eff ? nt_comp(w_code[j]) : w_code[j];
`ifdef ASCII2NT_BAD_EN
                        w_lane_bad[i]  = w_bad[j];
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        w_len_base = w_seq_start ? '0 : r_len;
        w_nc_base  = w_seq_start ? '0 : r_nc;
        w_len_sum  = {1'b0, w_len_base} + (LEN_W+1)'(w_k);
        w_nc_sum   = {1'b0, w_nc_base} + (LEN_W+1)'(w_nn);
        w_entry.nt     = w_nt;
        w_entry.keep   = w_keep;
        w_entry.last   = in_last;
        w_entry.len    = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
        w_entry.ncount = w_nc_sum[LEN_W]  ? '1 : w_nc_sum[LEN_W-1:0];
        w_entry.bad    = w_lane_bad;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
        else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b0;
            r_len      <= '0;
            r_nc       <= '0;
            r_rc_q     <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf[r_wr] <= w_entry;
                r_wr        <= ~r_wr;
                r_len       <= w_entry.len;
                r_nc        <= w_entry.ncount;
                if (w_seq_start) r_rc_q <= rc;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    assign out_valid  = (r_cnt != 2'd0);
    assign out_nt     = r_buf[r_rd].nt;
    assign out_keep   = r_buf[r_rd].keep;
    assign out_last   = r_buf[r_rd].last;
    assign out_len    = r_buf[r_rd].len;
    assign out_ncount = r_buf[r_rd].ncount;
    assign out_bad    = r_buf[r_rd].bad;

endmodule

// File: tb/tb_ascii2nt_stream.sv
// Directed bench for ascii2nt_stream (LANES=4, LEN_W=4); out_bad expectations follow ASCII2NT_BAD_EN.
module tb_ascii2nt_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ascii;
    logic [3:0]  in_keep;
    logic        in_last;
    logic        rc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_nt;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [3:0]  out_len;
    logic [3:0]  out_ncount;
    logic [3:0]  out_bad;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascii2nt_stream #(.LANES(4), .LEN_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ascii   (in_ascii),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .rc         (rc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nt     (out_nt),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_len    (out_len),
        .out_ncount (out_ncount),
        .out_bad    (out_bad)
    );

    function automatic logic [31:0] pack4(input logic [7:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [11:0] nt4(input logic [2:0] n0, n1, n2, n3);
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [3:0] bad_exp(input logic [3:0] b);
`ifdef ASCII2NT_BAD_EN
        return b;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [11:0] nt, input logic [3:0] keep,
                            input logic last, input logic [3:0] len, input logic [3:0] nc,
                            input logic [3:0] bad);
        chk({tag, ".valid"},  32'(out_valid),  32'd1);
        chk({tag, ".nt"},     32'(out_nt),     32'(nt));
        chk({tag, ".keep"},   32'(out_keep),   32'(keep));
        chk({tag, ".last"},   32'(out_last),   32'(last));
        chk({tag, ".len"},    32'(out_len),    32'(len));
        chk({tag, ".ncount"}, 32'(out_ncount), 32'(nc));
        chk({tag, ".bad"},    32'(out_bad),    32'(bad_exp(bad)));
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] k, input logic l, input logic r);
        in_ascii = a;
        in_keep  = k;
        in_last  = l;
        rc       = r;
        in_valid = 1'b1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [3:0] k, input logic l, input logic r);
        drive(a, k, l, r);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ascii  = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        rc        = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst.in_ready",  32'(in_ready),   32'd0);
        chk("rst.out_valid", 32'(out_valid),  32'd0);
        chk("rst.nt",        32'(out_nt),     32'd0);
        chk("rst.keep",      32'(out_keep),   32'd0);
        chk("rst.last",      32'(out_last),   32'd0);
        chk("rst.len",       32'(out_len),    32'd0);
        chk("rst.ncount",    32'(out_ncount), 32'd0);
        chk("rst.bad",       32'(out_bad),    32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel.in_ready",  32'(in_ready),   32'd1);
        chk("rel.out_valid", 32'(out_valid),  32'd0);

        beat(pack4("A", "C", "g", "T"), 4'b1111, 1'b1, 1'b0);
        chk_beat("fwd", nt4(1, 2, 3, 4), 4'b1111, 1'b1, 4'd4, 4'd0, 4'b0000);

        beat(pack4("A", "C", "g", "T"), 4'b1111, 1'b1, 1'b1);
        chk_beat("rc4", nt4(1, 2, 3, 4), 4'b1111, 1'b1, 4'd4, 4'd0, 4'b0000);

        beat(pack4("A", "A", "C", 8'h5F), 4'b0111, 1'b1, 1'b1);
        chk_beat("rc3", nt4(3, 4, 4, 0), 4'b0111, 1'b1, 4'd3, 4'd0, 4'b0000);

        beat(pack4("A", "A", "C", "C"), 4'b1111, 1'b0, 1'b1);
        chk_beat("seq2b1", nt4(3, 3, 4, 4), 4'b1111, 1'b0, 4'd4, 4'd0, 4'b0000);
        beat(pack4("A", "C", "G", "A"), 4'b0011, 1'b1, 1'b0);
        chk_beat("seq2b2", nt4(3, 4, 0, 0), 4'b0011, 1'b1, 4'd6, 4'd0, 4'b0000);
        beat(pack4("A", "A", "C", "C"), 4'b1111, 1'b1, 1'b0);
        chk_beat("seq3fwd", nt4(1, 1, 2, 2), 4'b1111, 1'b1, 4'd4, 4'd0, 4'b0000);

        beat(pack4("N", "N", "x", "A"), 4'b1111, 1'b1, 1'b0);
        chk_beat("nnxa", nt4(0, 0, 0, 1), 4'b1111, 1'b1, 4'd4, 4'd3, 4'b0100);
        beat(pack4("x", "A", "A", "A"), 4'b1111, 1'b1, 1'b1);
        chk_beat("xaaa_rc", nt4(4, 4, 4, 0), 4'b1111, 1'b1, 4'd4, 4'd1, 4'b1000);
        beat(pack4("A", "C", "G", "T"), 4'b0000, 1'b1, 1'b0);
        chk_beat("keep0", nt4(0, 0, 0, 0), 4'b0000, 1'b1, 4'd0, 4'd0, 4'b0000);

        // Backpressure: out_ready low across five edges while input keeps coming.
        tick();
        chk("drain.valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        drive(pack4("A", 8'h00, 8'h00, 8'h00), 4'b0001, 1'b0, 1'b0);
        tick();
        chk("bp1.in_ready", 32'(in_ready), 32'd1);
        drive(pack4("C", 8'h00, 8'h00, 8'h00), 4'b0001, 1'b0, 1'b0);
        tick();
        chk("bp2.in_ready", 32'(in_ready), 32'd0);
        drive(pack4("G", 8'h00, 8'h00, 8'h00), 4'b0001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
            chk_beat("bp_hold", nt4(1, 0, 0, 0), 4'b0001, 1'b0, 4'd1, 4'd0, 4'b0000);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_r1.in_ready", 32'(in_ready), 32'd1);
        chk_beat("bp_r1", nt4(2, 0, 0, 0), 4'b0001, 1'b0, 4'd2, 4'd0, 4'b0000);
        tick();
        chk("bp_r2.in_ready", 32'(in_ready), 32'd1);
        chk_beat("bp_r2", nt4(3, 0, 0, 0), 4'b0001, 1'b0, 4'd3, 4'd0, 4'b0000);
        drive(pack4("T", 8'h00, 8'h00, 8'h00), 4'b0001, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk_beat("bp_r3", nt4(4, 0, 0, 0), 4'b0001, 1'b1, 4'd4, 4'd0, 4'b0000);
        tick();
        chk("bp_end.valid", 32'(out_valid), 32'd0);

        // Saturating length counter, then reset in the middle of the sequence.
        beat(pack4("N", "A", "A", "A"), 4'b1111, 1'b0, 1'b0);
        chk_beat("sat1", nt4(0, 1, 1, 1), 4'b1111, 1'b0, 4'd4, 4'd1, 4'b0000);
        beat(pack4("N", "A", "A", "A"), 4'b1111, 1'b0, 1'b0);
        chk_beat("sat2", nt4(0, 1, 1, 1), 4'b1111, 1'b0, 4'd8, 4'd2, 4'b0000);
        beat(pack4("N", "A", "A", "A"), 4'b1111, 1'b0, 1'b0);
        chk_beat("sat3", nt4(0, 1, 1, 1), 4'b1111, 1'b0, 4'd12, 4'd3, 4'b0000);
        beat(pack4("N", "A", "A", "A"), 4'b1111, 1'b0, 1'b0);
        chk_beat("sat4", nt4(0, 1, 1, 1), 4'b1111, 1'b0, 4'd15, 4'd4, 4'b0000);
        beat(pack4("N", "A", "A", "A"), 4'b1111, 1'b0, 1'b0);
        chk_beat("sat5", nt4(0, 1, 1, 1), 4'b1111, 1'b0, 4'd15, 4'd5, 4'b0000);

        rst_n = 1'b0;
        tick();
        chk("mrst.in_ready",  32'(in_ready),   32'd0);
        chk("mrst.out_valid", 32'(out_valid),  32'd0);
        chk("mrst.nt",        32'(out_nt),     32'd0);
        chk("mrst.keep",      32'(out_keep),   32'd0);
        chk("mrst.last",      32'(out_last),   32'd0);
        chk("mrst.len",       32'(out_len),    32'd0);
        chk("mrst.ncount",    32'(out_ncount), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrel.in_ready",  32'(in_ready),   32'd1);
        chk("mrel.out_valid", 32'(out_valid),  32'd0);
        beat(pack4("A", "C", "G", "T"), 4'b0011, 1'b1, 1'b1);
        chk_beat("post_rst", nt4(3, 4, 0, 0), 4'b0011, 1'b1, 4'd2, 4'd0, 4'b0000);
        tick();
        chk("final.valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
